// File: rtl/sys_bus_arbiter.sv
// Round-robin arbiter sharing one system-bus memory port between NUM_REQ requesters.
// One access in flight at a time: IDLE -> ISSUE -> WAIT -> RESP, with a timeout on a silent memory.
module sys_bus_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int SYS_AW  = 32,
    parameter int SYS_DW  = 64,
    parameter int SYS_SW  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                      axi_clk_i,
    input  logic                      axi_rstn_i,
    input  logic [NUM_REQ*SYS_AW-1:0] s_addr_i,
    input  logic [NUM_REQ*SYS_DW-1:0] s_wdata_i,
    input  logic [NUM_REQ*SYS_SW-1:0] s_sel_i,
    input  logic [NUM_REQ-1:0]        s_wen_i,
    input  logic [NUM_REQ-1:0]        s_ren_i,
    output logic [SYS_DW-1:0]         s_rdata_o,
    output logic [NUM_REQ-1:0]        s_ack_o,
    output logic [NUM_REQ-1:0]        s_err_o,
    output logic [SYS_AW-1:0]         m_addr_o,
    output logic [SYS_DW-1:0]         m_wdata_o,
    output logic [SYS_SW-1:0]         m_sel_o,
    output logic                      m_wen_o,
    output logic                      m_ren_o,
    input  logic [SYS_DW-1:0]         m_rdata_i,
    input  logic                      m_ack_i,
    input  logic                      m_err_i,
    output logic [NUM_REQ-1:0]        grant_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_gidx;
    logic [NUM_REQ-1:0]  r_grant;
    logic                r_is_wr;
    logic [SYS_AW-1:0]   r_maddr;
    logic [SYS_DW-1:0]   r_mwdata;
    logic [SYS_SW-1:0]   r_msel;
    logic                r_mwen;
    logic                r_mren;
    logic [15:0]         r_cnt;
    logic [NUM_REQ-1:0]  r_sack;
    logic [NUM_REQ-1:0]  r_serr;
    logic [SYS_DW-1:0]   r_srdata;

    logic [NUM_REQ-1:0]  w_active;
    logic                w_pick_vld;
    logic [PTR_W-1:0]    w_pick_idx;
    logic [PTR_W-1:0]    w_ptr_next;
    logic                w_timeout;

    assign w_active   = s_wen_i | s_ren_i;
    assign w_ptr_next = (r_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;
    assign w_timeout  = (r_cnt == 16'(TIMEOUT));

    // Scan from the highest offset down so the nearest active index at/after the pointer wins.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            int idx;
            idx = int'(r_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (w_active[idx]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = PTR_W'(idx);
            end
        end
    end

    always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
        if (!axi_rstn_i) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_gidx   <= '0;
            r_grant  <= '0;
            r_is_wr  <= 1'b0;
            r_maddr  <= '0;
            r_mwdata <= '0;
            r_msel   <= '0;
            r_mwen   <= 1'b0;
            r_mren   <= 1'b0;
            r_cnt    <= '0;
            r_sack   <= '0;
            r_serr   <= '0;
            r_srdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_gidx   <= w_pick_idx;
                        r_grant  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
                        r_maddr  <= s_addr_i[w_pick_idx*SYS_AW +: SYS_AW];
                        r_mwdata <= s_wdata_i[w_pick_idx*SYS_DW +: SYS_DW];
                        r_msel   <= s_sel_i[w_pick_idx*SYS_SW +: SYS_SW];
                        // A requester raising both wen and ren is served as a write.
                        r_is_wr  <= s_wen_i[w_pick_idx];
                        r_mwen   <= s_wen_i[w_pick_idx];
                        r_mren   <= ~s_wen_i[w_pick_idx];
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_mwen  <= 1'b0;
                    r_mren  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (m_err_i) begin
                        r_serr  <= r_grant;
                        r_state <= ST_RESP;
                    end else if (m_ack_i) begin
                        r_sack   <= r_grant;
                        r_srdata <= r_is_wr ? '0 : m_rdata_i;
                        r_state  <= ST_RESP;
                    end else if (w_timeout) begin
                        r_serr  <= r_grant;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_RESP: begin
                    r_sack   <= '0;
                    r_serr   <= '0;
                    r_srdata <= '0;
                    r_grant  <= '0;
                    r_ptr    <= w_ptr_next;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_rdata_o = r_srdata;
    assign s_ack_o   = r_sack;
    assign s_err_o   = r_serr;
    assign m_addr_o  = r_maddr;
    assign m_wdata_o = r_mwdata;
    assign m_sel_o   = r_msel;
    assign m_wen_o   = r_mwen;
    assign m_ren_o   = r_mren;
    assign grant_o   = r_grant;

endmodule
